// File: rtl/regb.sv
// SAP-1 B register: captures the system bus on load and feeds the ALU B operand,
// with zero/sign status flags and a sticky "has been loaded" indicator.
module regb #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             msb,
    output logic             loaded
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             loaded_q, loaded_d;

    always_comb begin
        out_d    = out_q;
        loaded_d = loaded_q;
        if (load) begin
            out_d    = bus;
            loaded_d = 1'b1;
        end
    end

    // Asynchronous reset overrides any load sampled on a coincident edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q    <= RESET_VALUE;
            loaded_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            loaded_q <= loaded_d;
        end
    end

    assign out    = out_q;
    assign zero   = (out_q == '0);
    assign msb    = out_q[WIDTH-1];
    assign loaded = loaded_q;

endmodule

// File: tb/tb_regb.sv
// Self-checking bench for regb: directed test-plan scenarios plus randomized
// load/hold/async-reset traffic checked against a value-level reference model.
module tb_regb;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] bus;
    logic [W-1:0] out;
    logic         zero;
    logic         msb;
    logic         loaded;

    regb #(
        .WIDTH      (W),
        .RESET_VALUE(8'd0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .bus   (bus),
        .out   (out),
        .zero  (zero),
        .msb   (msb),
        .loaded(loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: the value the register should hold and whether it was loaded.
    logic [W-1:0] m_val;
    logic         m_loaded;

    function automatic logic [W+2:0] expect_vec(input logic [W-1:0] v, input logic l);
        return {v, (v == '0), v[W-1], l};
    endfunction

    task automatic test_reset();
        rst  = 1'b0;
        load = 1'b0;
        bus  = '0;
        @(negedge clk);
        m_val    = '0;
        m_loaded = 1'b0;
        checks++;
        if ({out, zero, msb, loaded} !== expect_vec(m_val, m_loaded))
            $display("FAIL reset: got out=%0d z=%b m=%b l=%b want %h",
                     out, zero, msb, loaded, expect_vec(m_val, m_loaded));
        else passes++;
        rst = 1'b1;
    endtask

    task automatic test_sequential_loads();
        logic [W-1:0] vals [4];
        vals = '{8'd64, 8'd56, 8'd94, 8'd255};
        foreach (vals[i]) begin
            @(negedge clk);
            load = 1'b1;
            bus  = vals[i];
            @(posedge clk);
            #1;
            m_val    = vals[i];
            m_loaded = 1'b1;
            checks++;
            if ({out, zero, msb, loaded} !== expect_vec(m_val, m_loaded))
                $display("FAIL seq_load[%0d]: got out=%0d z=%b m=%b l=%b want %h",
                         i, out, zero, msb, loaded, expect_vec(m_val, m_loaded));
            else passes++;
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        load = 1'b0;
        bus  = 8'd100;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out, zero, msb, loaded} !== expect_vec(8'd255, 1'b1))
                $display("FAIL hold: got out=%0d z=%b m=%b l=%b want out=255 l=1",
                         out, zero, msb, loaded);
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({out, zero, msb, loaded} !== expect_vec(8'd0, 1'b0))
            $display("FAIL async_reset: got out=%0d z=%b m=%b l=%b want out=0 l=0",
                     out, zero, msb, loaded);
        else passes++;
        load = 1'b1;
        bus  = 8'd170;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out, zero, msb, loaded} !== expect_vec(8'd0, 1'b0))
                $display("FAIL reset_hold: got out=%0d z=%b m=%b l=%b want out=0 l=0",
                         out, zero, msb, loaded);
            else passes++;
        end
    endtask

    task automatic test_release_load();
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b1;
        bus  = 8'd128;
        @(posedge clk);
        #1;
        checks++;
        if ({out, zero, msb, loaded} !== expect_vec(8'd128, 1'b1))
            $display("FAIL release_load: got out=%0d z=%b m=%b l=%b want out=128 l=1",
                     out, zero, msb, loaded);
        else passes++;
        @(negedge clk);
        bus = 8'd0;
        @(posedge clk);
        #1;
        checks++;
        if ({out, zero, msb, loaded} !== expect_vec(8'd0, 1'b1))
            $display("FAIL load_zero: got out=%0d z=%b m=%b l=%b want out=0 l=1",
                     out, zero, msb, loaded);
        else passes++;
    endtask

    // Reset falling on the same timestep as a loading edge must still win.
    task automatic test_simultaneous_reset();
        @(negedge clk);
        load = 1'b1;
        bus  = 8'd77;
        @(posedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({out, zero, msb, loaded} !== expect_vec(8'd0, 1'b0))
            $display("FAIL simul_reset: got out=%0d z=%b m=%b l=%b want out=0 l=0",
                     out, zero, msb, loaded);
        else passes++;
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        m_val    = '0;
        m_loaded = 1'b0;
    endtask

    task automatic test_random();
        logic         do_rst;
        logic [W-1:0] late_bus;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            load   = ($urandom_range(0, 2) != 0);
            bus    = W'($urandom);
            do_rst = ($urandom_range(0, 19) == 0);
            if (do_rst) begin
                #1;
                rst = 1'b0;
                #1;
                m_val    = '0;
                m_loaded = 1'b0;
                checks++;
                if ({out, zero, msb, loaded} !== expect_vec(m_val, m_loaded))
                    $display("FAIL rnd_reset[%0d]: got out=%0d l=%b want out=0 l=0",
                             n, out, loaded);
                else passes++;
                rst = 1'b1;
            end else begin
                #2;
            end
            // Bus settles mid-period; the edge must capture this final value.
            #1;
            late_bus = W'($urandom);
            bus      = late_bus;
            @(posedge clk);
            if (load) begin
                m_val    = late_bus;
                m_loaded = 1'b1;
            end
            #1;
            checks++;
            if ({out, zero, msb, loaded} !== expect_vec(m_val, m_loaded))
                $display("FAIL rnd_edge[%0d]: got out=%0d z=%b m=%b l=%b want %h",
                         n, out, zero, msb, loaded, expect_vec(m_val, m_loaded));
            else passes++;
            #1;
            bus = W'($urandom);
            #1;
            checks++;
            if ({out, zero, msb, loaded} !== expect_vec(m_val, m_loaded))
                $display("FAIL rnd_glitch[%0d]: got out=%0d l=%b want out=%0d l=%b",
                         n, out, loaded, m_val, m_loaded);
            else passes++;
        end
    endtask

    initial begin
        rst  = 1'b0;
        load = 1'b0;
        bus  = '0;
        test_reset();
        test_sequential_loads();
        test_hold();
        test_async_reset();
        test_release_load();
        m_val    = '0;
        m_loaded = 1'b1;
        test_simultaneous_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
